// File: rtl/dispatch_ctrl_if.sv
// Dispatch-to-issue-queue payload bundle: one-hot queue enable, operands, tags and the queues' ready flags.
interface dispatch_ctrl_if #(
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
);
  logic [3:0]        equeue_en;
  logic [3:0]        equeue_ready;
  logic [15:0]       equeue_imm;
  logic [TAG_W-1:0]  equeue_rdtag;
  logic [TAG_W-1:0]  equeue_rstag;
  logic [TAG_W-1:0]  equeue_rttag;
  logic [DATA_W-1:0] equeue_rsdata;
  logic [DATA_W-1:0] equeue_rtdata;
  logic              equeue_rsvalid;
  logic              equeue_rtvalid;
  logic [3:0]        equeue_opcode;

  modport master (
    output equeue_en, equeue_imm, equeue_rdtag, equeue_rstag, equeue_rttag,
    output equeue_rsdata, equeue_rtdata, equeue_rsvalid, equeue_rtvalid, equeue_opcode,
    input  equeue_ready
  );

  modport slave (
    input  equeue_en, equeue_imm, equeue_rdtag, equeue_rstag, equeue_rttag,
    input  equeue_rsdata, equeue_rtdata, equeue_rsvalid, equeue_rtvalid, equeue_opcode,
    output equeue_ready
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// In-order dispatch: decode, rename-tag allocation, operand capture with CDB forwarding/snooping,
// bounded branch speculation and flush/redirect on a taken branch.
module dispatch_ctrl #(
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BR_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ifq_inst,
  input  logic [31:0]       ifq_pcout_plus4,
  input  logic              ifq_empty,
  output logic              ifq_ren,
  output logic              ifq_branch_valid,
  output logic [31:0]       ifq_branch_addr,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              tag_empty,
  output logic              tag_ren,
  output logic              tag_ret_valid,
  output logic [TAG_W-1:0]  tag_ret,
  output logic [4:0]        src_rsaddr,
  output logic [4:0]        src_rtaddr,
  input  logic [TAG_W-1:0]  src_rstag,
  input  logic [TAG_W-1:0]  src_rttag,
  input  logic              src_rsvalid,
  input  logic              src_rtvalid,
  input  logic [DATA_W-1:0] src_rsdata,
  input  logic [DATA_W-1:0] src_rtdata,
  output logic              rst_wen,
  output logic [4:0]        rst_addr,
  output logic [TAG_W-1:0]  rst_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_branch,
  input  logic              cdb_branch_taken,
  input  logic [31:0]       cdb_branch_addr,
  dispatch_ctrl_if.master   eq
);

  localparam int unsigned BR_W = (BR_DEPTH < 1) ? 1 : $clog2(BR_DEPTH + 1);

  typedef enum logic [3:0] {
    Q_NONE = 4'b0000,
    Q_LS   = 4'b0001,
    Q_INT  = 4'b0010,
    Q_MULT = 4'b0100,
    Q_DIV  = 4'b1000
  } queue_e;

  logic [5:0]      op;
  logic [5:0]      func;
  queue_e          dec_q;
  logic [4:0]      dec_dest;
  logic            dec_wr;
  logic            dec_beq;
  logic            dec_j;
  logic [3:0]      dec_alu;
  logic [BR_W-1:0] br_cnt;
  logic            held, transfer, flush, resolve_nt, br_full, accept;
  logic            rs_hit, rt_hit;
  logic [31:0]     jump_target;
  logic            unused_pc;

  assign op          = ifq_inst[31:26];
  assign func        = ifq_inst[5:0];
  assign jump_target = {ifq_pcout_plus4[31:28], ifq_inst[25:0], 2'b00};
  assign unused_pc   = ^ifq_pcout_plus4[27:0];

  always_comb begin
    dec_q    = Q_INT;
    dec_dest = ifq_inst[20:16];
    dec_wr   = 1'b1;
    dec_beq  = 1'b0;
    dec_j    = 1'b0;
    dec_alu  = op[3:0];
    case (op)
      6'h00: begin
        dec_dest = ifq_inst[15:11];
        dec_alu  = func[3:0];
        if (func == 6'h18) begin
          dec_q   = Q_MULT;
          dec_alu = '0;
        end else if (func == 6'h1A) begin
          dec_q   = Q_DIV;
          dec_alu = '0;
        end
      end
      6'h23: begin
        dec_q   = Q_LS;
        dec_alu = 4'b0000;
      end
      6'h2B: begin
        dec_q   = Q_LS;
        dec_wr  = 1'b0;
        dec_alu = 4'b0001;
      end
      6'h04: begin
        dec_beq = 1'b1;
        dec_wr  = 1'b0;
      end
      6'h02: begin
        dec_q  = Q_NONE;
        dec_j  = 1'b1;
        dec_wr = 1'b0;
      end
      default: ;
    endcase
  end

  assign held       = |eq.equeue_en;
  assign transfer   = |(eq.equeue_en & eq.equeue_ready);
  assign flush      = cdb_branch & cdb_branch_taken;
  assign resolve_nt = cdb_branch & ~cdb_branch_taken;
  // A same-cycle not-taken resolution frees a slot for the BEQ at the head.
  assign br_full    = dec_beq && (br_cnt == BR_W'(BR_DEPTH)) && !resolve_nt;
  assign accept     = !reset && !ifq_empty && (!held || transfer) && (!tag_empty || dec_j)
                      && !br_full && !flush;

  assign ifq_ren    = accept;
  assign tag_ren    = accept && !dec_j;
  assign rst_wen    = accept && dec_wr && (dec_dest != 5'd0);
  assign rst_addr   = rst_wen ? dec_dest : '0;
  assign rst_tag    = rst_wen ? tag_in : '0;
  assign src_rsaddr = reset ? '0 : ifq_inst[25:21];
  assign src_rtaddr = reset ? '0 : ifq_inst[20:16];
  assign rs_hit     = cdb_valid && (cdb_tag == src_rstag);
  assign rt_hit     = cdb_valid && (cdb_tag == src_rttag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt            <= '0;
      ifq_branch_valid  <= 1'b0;
      ifq_branch_addr   <= '0;
      tag_ret_valid     <= 1'b0;
      tag_ret           <= '0;
      eq.equeue_en      <= '0;
      eq.equeue_imm     <= '0;
      eq.equeue_rdtag   <= '0;
      eq.equeue_rstag   <= '0;
      eq.equeue_rttag   <= '0;
      eq.equeue_rsdata  <= '0;
      eq.equeue_rtdata  <= '0;
      eq.equeue_rsvalid <= 1'b0;
      eq.equeue_rtvalid <= 1'b0;
      eq.equeue_opcode  <= '0;
    end else begin
      ifq_branch_valid <= flush || (accept && dec_j);
      ifq_branch_addr  <= flush ? cdb_branch_addr : ((accept && dec_j) ? jump_target : '0);
      tag_ret_valid    <= flush && held;
      tag_ret          <= (flush && held) ? eq.equeue_rdtag : '0;

      if (flush)
        br_cnt <= '0;
      else if (accept && dec_beq && !resolve_nt)
        br_cnt <= br_cnt + BR_W'(1);
      else if (!(accept && dec_beq) && resolve_nt && (br_cnt != '0))
        br_cnt <= br_cnt - BR_W'(1);

      if (flush) begin
        eq.equeue_en <= '0;
      end else if (accept && !dec_j) begin
        eq.equeue_en      <= dec_q;
        eq.equeue_imm     <= ifq_inst[15:0];
        eq.equeue_rdtag   <= tag_in;
        eq.equeue_rstag   <= src_rstag;
        eq.equeue_rttag   <= src_rttag;
        eq.equeue_rsvalid <= src_rsvalid || rs_hit;
        eq.equeue_rtvalid <= src_rtvalid || rt_hit;
        eq.equeue_rsdata  <= src_rsvalid ? src_rsdata : cdb_data;
        eq.equeue_rtdata  <= src_rtvalid ? src_rtdata : cdb_data;
        eq.equeue_opcode  <= dec_alu;
      end else if (transfer) begin
        eq.equeue_en <= '0;
      end else if (held) begin
        if (!eq.equeue_rsvalid && cdb_valid && (cdb_tag == eq.equeue_rstag)) begin
          eq.equeue_rsvalid <= 1'b1;
          eq.equeue_rsdata  <= cdb_data;
        end
        if (!eq.equeue_rtvalid && cdb_valid && (cdb_tag == eq.equeue_rttag)) begin
          eq.equeue_rtvalid <= 1'b1;
          eq.equeue_rtdata  <= cdb_data;
        end
      end
    end
  end

endmodule
